// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a FIFO read port onto a valid/ready stream through a 2-entry buffer.
// Latency: rinc in cycle k -> word captured at edge k+2; 1 word/cycle sustained.
// Backpressure: buf_cnt + inflight <= 2 credit limit stops rinc while the consumer stalls.
// Optional: define FIFO_RD_CNT_EN to add the xfer_cnt/cnt_clr pop counter.
module fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rd_en,
    input  logic             rempty,
    input  logic [WIDTH-1:0] rdata,
    output logic             rinc,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
`ifdef FIFO_RD_CNT_EN
    input  logic             cnt_clr,
    output logic [15:0]      xfer_cnt,
`endif
    output logic             busy
);

    generate
        if (BUF_DEPTH != 2) begin : g_bad_depth
            $error("fifo_rd_stream: BUF_DEPTH must be 2");
        end
    endgenerate

    logic [1:0]       buf_cnt;
    logic             inflight;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [WIDTH-1:0] mem [0:1];
    logic             pop;
    logic [2:0]       credit_used;

    assign pop         = dout_valid & dout_ready;
    // A word leaving this cycle frees its slot in time for the read issued now.
    assign credit_used = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rinc        = rstn & rd_en & ~rempty & (credit_used < 3'd2);

    assign dout       = mem[rd_ptr];
    assign dout_valid = (buf_cnt != 2'd0);
    assign busy       = dout_valid | inflight;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            inflight <= rinc;
            buf_cnt  <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
            // rdata is the RAM's registered output for the rinc sampled one edge ago.
            if (inflight) begin
                mem[wr_ptr] <= rdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xfer_cnt <= 16'd0;
        end else if (cnt_clr) begin
            xfer_cnt <= 16'd0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO read-port model plus stream monitor; words must leave in push order.
module tb_fifo_rd_stream;
    localparam int W     = 8;
    localparam int MEMSZ = 131072;

    logic         clk = 1'b0;
    logic         rstn;
    logic         rd_en;
    logic         rempty = 1'b1;
    logic [W-1:0] rdata  = '0;
    logic         rinc;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
`ifdef FIFO_RD_CNT_EN
    logic         cnt_clr;
    logic [15:0]  xfer_cnt;
`endif

    fifo_rd_stream #(.WIDTH(W), .BUF_DEPTH(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rd_en      (rd_en),
        .rempty     (rempty),
        .rdata      (rdata),
        .rinc       (rinc),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef FIFO_RD_CNT_EN
        .cnt_clr    (cnt_clr),
        .xfer_cnt   (xfer_cnt),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: words written by tasks at wr_n, read by rinc at rd_n, 1-cycle read latency.
    logic [W-1:0] fifo_mem [0:MEMSZ-1];
    int           wr_n      = 0;
    int           rd_n      = 0;
    int           underflow = 0;
    logic         flush     = 1'b0;

    always @(posedge clk) begin
        logic [W-1:0] nxt;
        nxt = rdata;
        if (rinc) begin
            if (rd_n >= wr_n) underflow++;
            else begin
                nxt = fifo_mem[rd_n % MEMSZ];
                rd_n++;
            end
        end
        #1 rdata = nxt;
        #1 if (flush) rd_n = wr_n;
        rempty = (rd_n >= wr_n);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records delivered words and protocol violations at the falling edge.
    logic [W-1:0] rx_q [$];
    int           rx_cyc [$];
    int           rinc_cyc [$];
    int           rinc_cnt = 0;
    int           stab_err = 0;
    int           inv_err  = 0;
    int           rinc_empty_err = 0;
    int           fall_cyc = -100;
    logic         prev_rempty = 1'b1;
    logic         hold_prev = 1'b0;
    logic [W-1:0] prev_dout = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            hold_prev   = 1'b0;
            prev_rempty = rempty;
        end else begin
            if (dout_valid && dout_ready) begin
                rx_q.push_back(dout);
                rx_cyc.push_back(cyc);
            end
            if (rinc) begin
                rinc_cnt++;
                rinc_cyc.push_back(cyc);
            end
            if (rinc && rempty) rinc_empty_err++;
            if (int'(dut.buf_cnt) + int'(dut.inflight) > 2) inv_err++;
            if (hold_prev && (!dout_valid || dout !== prev_dout)) stab_err++;
            hold_prev = dout_valid && !dout_ready;
            prev_dout = dout;
            if (prev_rempty && !rempty) fall_cyc = cyc;
            prev_rempty = rempty;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        fifo_mem[wr_n % MEMSZ] = d;
        wr_n++;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; rd_en = 1'b0; dout_ready = 1'b0;
`ifdef FIFO_RD_CNT_EN
        cnt_clr = 1'b0;
`endif
        step(2);
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", dout_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (rinc !== 1'b0) $display("FAIL reset_rinc got %b exp 0", rinc); else n_pass++;
        n_checks++; if (dout !== 8'h00) $display("FAIL reset_dout got %h exp 00", dout); else n_pass++;
`ifdef FIFO_RD_CNT_EN
        n_checks++; if (xfer_cnt !== 16'h0) $display("FAIL reset_xfer_cnt got %h exp 0000", xfer_cnt); else n_pass++;
`endif
        rstn = 1'b1;
        step();
    endtask

    task automatic test_preload();
        logic [W-1:0] exp_d [3];
        int base, rb;
        exp_d = '{8'h11, 8'h22, 8'h33};
        base = rx_q.size(); rb = rinc_cyc.size();
        rd_en = 1'b1; dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(exp_d[i]);
        step();
        wait_rx(base + 3, 20);
        step(2);
        n_checks++; if (rx_q.size() - base != 3) $display("FAIL preload_count got %0d exp 3", rx_q.size() - base); else n_pass++;
        n_checks++; if (rinc_cyc.size() - rb != 3) $display("FAIL preload_rinc_count got %0d exp 3", rinc_cyc.size() - rb); else n_pass++;
        if (rx_q.size() - base >= 3 && rinc_cyc.size() - rb >= 3) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (rx_q[base+i] !== exp_d[i]) $display("FAIL preload_data[%0d] got %h exp %h", i, rx_q[base+i], exp_d[i]); else n_pass++;
            end
            n_checks++; if (rinc_cyc[rb+2] - rinc_cyc[rb] != 2) $display("FAIL preload_rinc_consecutive span %0d exp 2", rinc_cyc[rb+2] - rinc_cyc[rb]); else n_pass++;
            n_checks++; if (rx_cyc[base] - fall_cyc != 2) $display("FAIL preload_latency got %0d exp 2", rx_cyc[base] - fall_cyc); else n_pass++;
            n_checks++; if (rx_cyc[base+2] - rx_cyc[base] != 2) $display("FAIL preload_out_consecutive span %0d exp 2", rx_cyc[base+2] - rx_cyc[base]); else n_pass++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL preload_busy_after got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        int base, rb, se;
        base = rx_q.size(); rb = rinc_cnt; se = stab_err;
        rd_en = 1'b1; dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        step(8);
        n_checks++; if (rinc_cnt - rb != 2) $display("FAIL bp_rinc_pulses got %0d exp 2", rinc_cnt - rb); else n_pass++;
        n_checks++; if (dut.buf_cnt !== 2'd2) $display("FAIL bp_buf_cnt got %0d exp 2", dut.buf_cnt); else n_pass++;
        n_checks++; if (dout !== 8'hA0 || dout_valid !== 1'b1) $display("FAIL bp_head got %h/%b exp a0/1", dout, dout_valid); else n_pass++;
        n_checks++; if (stab_err != se) $display("FAIL bp_stable got %0d violations exp 0", stab_err - se); else n_pass++;
        dout_ready = 1'b1;
        wait_rx(base + 8, 40);
        n_checks++; if (rx_q.size() - base != 8) $display("FAIL bp_count got %0d exp 8", rx_q.size() - base); else n_pass++;
        if (rx_q.size() - base >= 8) begin
            for (int i = 0; i < 8; i++) begin
                n_checks++; if (rx_q[base+i] !== 8'hA0 + 8'(i)) $display("FAIL bp_data[%0d] got %h exp %h", i, rx_q[base+i], 8'hA0 + 8'(i)); else n_pass++;
            end
            n_checks++; if (rx_cyc[base+7] - rx_cyc[base] != 7) $display("FAIL bp_rate span %0d exp 7", rx_cyc[base+7] - rx_cyc[base]); else n_pass++;
        end
        step(2);
    endtask

    task automatic test_toggle();
        int base, se, k;
        base = rx_q.size(); se = stab_err; k = 0;
        for (int i = 1; i <= 6; i++) push(8'(i));
        while (rx_q.size() < base + 6 && k < 60) begin
            dout_ready = (k % 2 == 0);
            step();
            k++;
        end
        dout_ready = 1'b1;
        step(3);
        n_checks++; if (rx_q.size() - base != 6) $display("FAIL toggle_count got %0d exp 6", rx_q.size() - base); else n_pass++;
        if (rx_q.size() - base >= 6) begin
            for (int i = 0; i < 6; i++) begin
                n_checks++; if (rx_q[base+i] !== 8'(i + 1)) $display("FAIL toggle_data[%0d] got %h exp %h", i, rx_q[base+i], 8'(i + 1)); else n_pass++;
            end
        end
        n_checks++; if (inv_err != 0) $display("FAIL toggle_credit got %0d violations exp 0", inv_err); else n_pass++;
        n_checks++; if (stab_err != se) $display("FAIL toggle_stable got %0d violations exp 0", stab_err - se); else n_pass++;
    endtask

    task automatic test_rempty_midburst();
        int base, rb, re;
        base = rx_q.size(); rb = rinc_cnt; re = rinc_empty_err;
        dout_ready = 1'b1;
        push(8'h3C); push(8'h5A);
        wait_rx(base + 2, 20);
        step(3);
        n_checks++; if (rx_q.size() - base != 2) $display("FAIL midburst_count got %0d exp 2", rx_q.size() - base); else n_pass++;
        if (rx_q.size() - base >= 2) begin
            n_checks++; if (rx_q[base+1] !== 8'h5A) $display("FAIL midburst_last got %h exp 5a", rx_q[base+1]); else n_pass++;
        end
        n_checks++; if (rinc_cnt - rb != 2) $display("FAIL midburst_rinc got %0d exp 2", rinc_cnt - rb); else n_pass++;
        n_checks++; if (rinc_empty_err != re) $display("FAIL midburst_rinc_while_empty got %0d exp 0", rinc_empty_err - re); else n_pass++;
        n_checks++; if (underflow != 0) $display("FAIL midburst_underflow got %0d exp 0", underflow); else n_pass++;
    endtask

    task automatic test_rd_en();
        int base, rb;
        base = rx_q.size();
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        step(6);
        rd_en = 1'b0; rb = rinc_cnt; dout_ready = 1'b1;
        step(6);
        n_checks++; if (rinc_cnt - rb != 0) $display("FAIL rd_en_rinc got %0d exp 0", rinc_cnt - rb); else n_pass++;
        n_checks++; if (rx_q.size() - base != 2) $display("FAIL rd_en_drain got %0d exp 2", rx_q.size() - base); else n_pass++;
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL rd_en_empty_valid got %b exp 0", dout_valid); else n_pass++;
        rd_en = 1'b1;
        wait_rx(base + 4, 20);
        n_checks++; if (rx_q.size() - base != 4) $display("FAIL rd_en_count got %0d exp 4", rx_q.size() - base); else n_pass++;
        if (rx_q.size() - base >= 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (rx_q[base+i] !== 8'hC0 + 8'(i)) $display("FAIL rd_en_data[%0d] got %h exp %h", i, rx_q[base+i], 8'hC0 + 8'(i)); else n_pass++;
            end
        end
        step(2);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_d [16];
        int base;
        base = rx_q.size();
        dout_ready = 1'b1; rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_d[i] = 8'($urandom);
            push(exp_d[i]);
        end
        step(4);
        n_checks++; if (dut.buf_cnt !== 2'd1 || dut.inflight !== 1'b1 || rinc !== 1'b1)
            $display("FAIL b2b_steady got buf=%0d infl=%b rinc=%b exp 1/1/1", dut.buf_cnt, dut.inflight, rinc); else n_pass++;
        wait_rx(base + 16, 40);
        n_checks++; if (rx_q.size() - base != 16) $display("FAIL b2b_count got %0d exp 16", rx_q.size() - base); else n_pass++;
        if (rx_q.size() - base >= 16) begin
            for (int i = 0; i < 16; i++) begin
                n_checks++; if (rx_q[base+i] !== exp_d[i]) $display("FAIL b2b_data[%0d] got %h exp %h", i, rx_q[base+i], exp_d[i]); else n_pass++;
            end
            n_checks++; if (rx_cyc[base+15] - rx_cyc[base] != 15) $display("FAIL b2b_rate span %0d exp 15", rx_cyc[base+15] - rx_cyc[base]); else n_pass++;
        end
        step(2);
    endtask

    task automatic test_random();
        logic [W-1:0] exp_d [$];
        logic [W-1:0] d;
        int base, se;
        base = rx_q.size(); se = stab_err;
        for (int c = 0; c < 300; c++) begin
            dout_ready = ($urandom_range(0, 3) != 0);
            rd_en      = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) begin
                d = 8'($urandom);
                exp_d.push_back(d);
                push(d);
            end
            step();
        end
        dout_ready = 1'b1; rd_en = 1'b1;
        wait_rx(base + exp_d.size(), 400);
        n_checks++; if (rx_q.size() - base != exp_d.size()) $display("FAIL rand_count got %0d exp %0d", rx_q.size() - base, exp_d.size()); else n_pass++;
        if (rx_q.size() - base >= exp_d.size()) begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_checks++; if (rx_q[base+i] !== exp_d[i]) $display("FAIL rand_data[%0d] got %h exp %h", i, rx_q[base+i], exp_d[i]); else n_pass++;
            end
        end
        n_checks++; if (inv_err != 0) $display("FAIL rand_credit got %0d violations exp 0", inv_err); else n_pass++;
        n_checks++; if (stab_err != se) $display("FAIL rand_stable got %0d violations exp 0", stab_err - se); else n_pass++;
        n_checks++; if (underflow != 0) $display("FAIL rand_underflow got %0d exp 0", underflow); else n_pass++;
        step(2);
    endtask

    task automatic test_reset_inflight();
        int base, k;
        logic found;
        dout_ready = 1'b0; rd_en = 1'b1; found = 1'b0; k = 0;
        for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
        while (!found && k < 10) begin
            step();
            k++;
            found = (dut.inflight === 1'b1 && dut.buf_cnt === 2'd1);
        end
        n_checks++; if (found !== 1'b1) $display("FAIL rst_mid_state got %b exp 1", found); else n_pass++;
        rstn = 1'b0; flush = 1'b1;
        #1;
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL rst_mid_valid got %b exp 0", dout_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (rinc !== 1'b0) $display("FAIL rst_mid_rinc got %b exp 0", rinc); else n_pass++;
        step();
        flush = 1'b0;
        step();
        rstn = 1'b1; dout_ready = 1'b1;
        base = rx_q.size();
        step(6);
        n_checks++; if (rx_q.size() - base != 0) $display("FAIL rst_mid_stale got %0d words exp 0", rx_q.size() - base); else n_pass++;
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL rst_mid_after_valid got %b exp 0", dout_valid); else n_pass++;
    endtask

`ifdef FIFO_RD_CNT_EN
    task automatic test_cnt();
        int base, n0;
        logic [15:0] e;
        dout_ready = 1'b1; rd_en = 1'b1;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_checks++; if (xfer_cnt !== 16'h0) $display("FAIL cnt_clear got %h exp 0000", xfer_cnt); else n_pass++;
        base = rx_q.size();
        for (int i = 0; i < 65536; i++) push(8'(i));
        wait_rx(base + 65536, 70000);
        step(3);
        n_checks++; if (rx_q.size() - base != 65536) $display("FAIL cnt_pops got %0d exp 65536", rx_q.size() - base); else n_pass++;
        n_checks++; if (xfer_cnt !== 16'h0000) $display("FAIL cnt_wrap got %h exp 0000", xfer_cnt); else n_pass++;
        base = rx_q.size();
        for (int i = 0; i < 6; i++) push(8'h70 + 8'(i));
        wait_rx(base + 2, 20);
        n_checks++; if (dout_valid !== 1'b1) $display("FAIL cnt_clr_pop_valid got %b exp 1", dout_valid); else n_pass++;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n0 = rx_q.size();
        n_checks++; if (xfer_cnt !== 16'h0) $display("FAIL cnt_clr_with_pop got %h exp 0000", xfer_cnt); else n_pass++;
        wait_rx(base + 6, 20);
        step(2);
        e = 16'(rx_q.size() - n0);
        n_checks++; if (xfer_cnt !== e) $display("FAIL cnt_after_clr got %h exp %h", xfer_cnt, e); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_preload();
        test_backpressure();
        test_toggle();
        test_rempty_midburst();
        test_rd_en();
        test_back_to_back();
        test_random();
        test_reset_inflight();
`ifdef FIFO_RD_CNT_EN
        test_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
